data_memory_responder: RTL
==========================

Name: data_memory_responder

Overview:
- Responder side of the CPU load/store data interface: accepts one read or write request at a time from the core (initiator) over a valid/ready handshake.
- Returns a response after a fixed, parameterised latency, also over a valid/ready handshake.
- Backed by a word-organised RAM of DEPTH 32-bit words with byte write strobes.
- Replaces the zero-latency register-style data path so the core and its benches can exercise multi-cycle memory.

Parameters:
DEPTH, 32, number of 32-bit words; legal word indices 0..DEPTH-1
LATENCY, 2, rising edges from request acceptance to resp_valid; legal range 1..15

Ports:
clk  input  1  clock, rising-edge active
reset  input  1  asynchronous, active-high reset
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_addr  input  32  byte address
req_write  input  1  1 = store, 0 = load
req_wdata  input  32  store data
req_wstrb  input  4  byte enables; bit k covers bits 8k+7:8k
resp_valid  output  1  response available
resp_ready  input  1  initiator accepts the response
resp_rdata  output  32  load data; 0 for stores and errors
resp_error  output  1  misaligned or out-of-range access
mem_check  output  DEPTH x 32  debug view of all words, combinational from storage

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is asynchronous and active-high.
  - While reset=1: state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_error=0, and word i = 4000+i for i=0..DEPTH-1.
  - req_ready=1 once in IDLE.
- States: IDLE, WAIT, RESP.
  - req_ready=1 only in IDLE.
  - resp_valid=1 only in RESP.
- Accept:
  - Occurs at a rising edge where state=IDLE and req_valid=1.
  - Latch addr, write, wdata and wstrb at that edge; later changes to req_* are ignored.
  - If LATENCY=1, next state is RESP; otherwise WAIT with counter=LATENCY-1.
- WAIT:
  - Each edge: if counter==1, go to RESP; else decrement the counter.
  - resp_valid therefore first reads 1 after the LATENCY-th edge, counting the accept edge as edge 1.
- Completion (the edge entering RESP):
  - Error if latched addr[1:0]!=0 or addr[31:2]>=DEPTH.
  - Error case: resp_error=1, resp_rdata=0, no storage change.
  - Store without error: each byte with wstrb[k]=1 is written; resp_rdata=0. wstrb=0 completes normally with no change.
  - Load without error: resp_rdata = word at completion time.
- RESP:
  - resp_rdata and resp_error are held stable while resp_ready=0; no timeout.
  - An edge with resp_ready=1 returns to IDLE and clears resp_valid, resp_rdata and resp_error to 0.
  - One IDLE cycle is mandatory between transactions; minimum period is LATENCY+1 cycles.
  - req_valid during WAIT or RESP is not accepted. The initiator holds it; no queuing.
- Reset mid-transaction: the transaction is dropped, a pending store is not performed, and memory is re-initialised.
- Storage width: word index is addr[31:2] compared at full width, so there is no aliasing/wrap for addresses at or beyond 4*DEPTH.
- mem_check reflects stores in the same cycle they complete.

Test Plan:
- Reset then idle: reset pulse -> req_ready=1, resp_valid=0, mem_check[5]=4005, mem_check[31]=4031.
- Load, LATENCY=2: req addr=0x14 load, resp_ready=1 -> resp_valid high exactly 2 edges after accept with rdata=4005, error=0. Returns to IDLE next edge; req_ready high one cycle later.
- Byte store:
  - Store addr=0x08, wdata=0xdeadbeef, wstrb=4'b0011 -> mem_check[2]=(4002 & 0xffff0000)|0xbeef, resp_rdata=0.
  - Follow-up load of 0x08 returns the same value.
- Backpressure: load addr=0x04 with resp_ready=0 for 5 cycles -> resp_valid and rdata=4001 held stable. req_valid=1 with a new request during that time is not accepted (req_ready=0). Drops after resp_ready=1.
- Errors:
  - Load addr=0x06 -> resp_error=1, rdata=0.
  - Store addr=0x80 (DEPTH=32) -> resp_error=1, all mem_check unchanged.
- Reset mid-operation: store to 0x0c accepted, reset asserted during WAIT -> resp_valid never rises, mem_check[3]=4003. LATENCY=1 build: load 0x00 -> resp_valid after the accept edge, rdata=4000.

Source files
------------

// File: rtl/data_memory_responder.sv
// Responder for the core's load/store data port: one request at a time over valid/ready,
// answered after LATENCY edges from a byte-strobed word RAM that resets to 4000+index.
module data_memory_responder #(
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    input  logic                  req_write,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [DEPTH-1:0][31:0] mem_check,
    output logic [1:0]            dbg_state
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // req_ready is high only in IDLE, resp_valid only in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    counter;
    logic [31:0]   lat_addr;
    logic          lat_write;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_wstrb;
    logic [31:0]   mem [DEPTH];

    logic [31:0]   c_addr;
    logic          c_write;
    logic [31:0]   c_wdata;
    logic [3:0]    c_wstrb;
    logic          complete;
    logic          c_err;
    logic [IW-1:0] c_idx;
    logic [31:0]   c_word;
    logic [31:0]   c_merged;

    // With LATENCY=1 completion coincides with the accept edge, so the live request is used.
    always_comb begin
        c_addr   = (state == IDLE) ? req_addr  : lat_addr;
        c_write  = (state == IDLE) ? req_write : lat_write;
        c_wdata  = (state == IDLE) ? req_wdata : lat_wdata;
        c_wstrb  = (state == IDLE) ? req_wstrb : lat_wstrb;
        complete = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                   ((state == WAIT) && (counter == 4'd1));
        c_err    = (c_addr[1:0] != 2'b00) || (c_addr[31:2] >= 30'(DEPTH));
        c_idx    = c_addr[IW+1:2];
        c_word   = mem[c_idx];
        c_merged = c_word;
        for (int k = 0; k < 4; k++) begin
            if (c_wstrb[k]) c_merged[8*k +: 8] = c_wdata[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= 4'd0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            lat_addr   <= 32'd0;
            lat_write  <= 1'b0;
            lat_wdata  <= 32'd0;
            lat_wstrb  <= 4'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'(4000 + i);
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_write <= req_write;
                        lat_wdata <= req_wdata;
                        lat_wstrb <= req_wstrb;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state   <= WAIT;
                            counter <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (counter == 4'd1) begin
                        state   <= RESP;
                        counter <= 4'd0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_rdata <= 32'd0;
                        resp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            if (complete) begin
                resp_error <= c_err;
                resp_rdata <= (c_err || c_write) ? 32'd0 : c_word;
                if (!c_err && c_write) mem[c_idx] <= c_merged;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dbg_state  = state;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_check[i] = mem[i];
        end
    end

endmodule
